hack_kbd_ps2_rx: RTL and testbench
==================================

Name: hack_kbd_ps2_rx

Overview:
PS/2 keyboard receiver that produces the 16-bit keyboard word read at the Hack memory map's keyboard address (0x6000). It sits directly upstream of the memory read-data 4-way 16-bit selector, which picks among RAM, screen and keyboard words. It deserialises PS/2 device-to-host frames, tracks make/break/extended prefixes, and holds the scancode of the currently pressed key, or 0 when no key is held.

Parameters:
FILTER_LEN, 8, cycles ps2_clk must be stable at its new level before the edge is accepted (glitch filter).
TIMEOUT_CYCLES, 50000, max clk cycles between accepted falling edges inside a frame before abort.
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
ps2_clk  input  1  raw PS/2 clock from pin, asynchronous
ps2_data  input  1  raw PS/2 data from pin, asynchronous
key_out  output  16  keyboard word to memory read mux: {7'b0, ext, code[7:0]}, 0 = no key
key_strobe  output  1  one-cycle pulse whenever key_out changes value
frame_err  output  1  one-cycle pulse on parity error, bad start/stop bit, or timeout

Behaviour:
- Reset (async assert, sync release): key_out=0, key_strobe=0, frame_err=0, FSM=IDLE, break_pend=0, ext_pend=0, bit counter=0, timeout counter=0, filtered clock=1.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Glitch filter: the filtered clock changes only after the synchronised ps2_clk differs from it for FILTER_LEN consecutive cycles.
- A falling edge of the filtered clock produces a 1-cycle fall_tick. Data is sampled from synchronised ps2_data on fall_tick.
- FSM states and transitions:
  IDLE: on fall_tick, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE and pulse frame_err.
  DATA: shift 8 bits LSB first. After the 8th bit go to PARITY.
  PARITY: sample the parity bit, go to STOP.
  STOP: sample the stop bit. If stop=1 and the XOR of the 8 data bits plus the parity bit is 1 (odd parity), the byte is good. Otherwise pulse frame_err and discard the byte. Return to IDLE in either case.
- Timeout: in any non-IDLE state, the counter increments each cycle and clears on fall_tick. When it reaches TIMEOUT_CYCLES: pulse frame_err, return to IDLE, discard partial data. break_pend and ext_pend are unchanged.
- Good byte decode, one cycle after the STOP sample:
  0xE0: ext_pend=1.
  0xF0: break_pend=1.
  Any other value C, with break_pend=0: key_out = {7'b0, ext_pend, C}. Typematic repeat of the same code leaves key_out unchanged and produces no strobe.
  Any other value C, with break_pend=1: if {ext_pend, C} equals key_out[8:0], key_out=0; otherwise key_out is unchanged (release of a non-current key).
  After any non-prefix byte, clear break_pend and ext_pend.
- key_strobe pulses high for exactly one cycle, in the same cycle key_out updates, and only if the value actually changed.
- Latency: key_out updates 2 clk cycles after the clk edge on which the stop bit is sampled (1 cycle for the STOP check, 1 for decode). The filter adds FILTER_LEN+2 cycles from the pin edge.
- key_out is registered and stable between updates; the downstream mux reads it combinationally.
- Reset asserted mid-frame aborts immediately. No partial state survives reset.
- The block never drives the PS/2 lines (receive only, no host-to-device commands).

Test Plan:
- Reset with ps2_clk=1, ps2_data=1: key_out=0x0000, key_strobe=0, frame_err=0.
- Press frame 0x1C (start 0, bits LSB first, parity 0, stop 1): key_out=0x001C, one key_strobe pulse. Then frames F0,1C: key_out=0x0000, second strobe pulse.
- Extended key, frames E0,75: key_out=0x0175. Then E0,F0,75: key_out=0x0000. Frame 1C sent again twice: key_out=0x001C with a single strobe only.
- Frame 0x1C with parity bit 1: frame_err pulses once, key_out unchanged. The next valid frame 0x32 is accepted (key_out=0x0032).
- Stop after 4 data bits and hold ps2_clk high: after TIMEOUT_CYCLES frame_err pulses and FSM is in IDLE. The next full frame 0x1C decodes correctly. Separately, 3-cycle low glitches on ps2_clk with FILTER_LEN=8 cause no bit to be sampled.
- Press 0x1C, press 0x32, then send F0,1C: key_out stays 0x0032. Assert rst mid-frame: key_out=0 at once, and the following clean frame decodes correctly.

Source files
------------

// File: rtl/hack_kbd_ps2_rx.sv
// PS/2 keyboard receiver producing the Hack keyboard word (memory address 0x6000).
// It deserialises device-to-host frames and tracks the E0 (extended) and F0 (break) prefixes.
// key_out holds {7'b0, ext, code} for the key currently held, or 0 when no key is held.
module hack_kbd_ps2_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key_out,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int unsigned FCNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam int unsigned KEY_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BCNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [1:0]        clk_sync_q;
  logic [1:0]        dat_sync_q;
  logic              clk_s;
  logic              dat_s;

  logic              filt_q,  filt_d;
  logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
  logic              fall_q,  fall_d;

  state_e            state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              par_q,   par_d;
  logic              stop_q,  stop_d;
  logic              chk_q,   chk_d;
  logic              good_q,  good_d;
  logic [CNT_W-1:0]  tmo_q,   tmo_d;

  logic              brk_q,   brk_d;
  logic              ext_q,   ext_d;
  logic [KEY_W-1:0]  key_q,   key_d;
  logic              strobe_q, strobe_d;
  logic              err_q,   err_d;

  logic [KEY_W-1:0]  new_key;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Two-flop synchronisers for the asynchronous PS/2 pins (idle level is high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  // Glitch filter: follow the synchronised clock only after FILTER_LEN cycles of disagreement
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Frame FSM, timeout, byte check and make/break decode (fall_q is the sample tick)
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    stop_d    = stop_q;
    chk_d     = 1'b0;
    good_d    = 1'b0;
    tmo_d     = '0;
    err_d     = 1'b0;
    brk_d     = brk_q;
    ext_d     = ext_q;
    key_d     = key_q;
    strobe_d  = 1'b0;
    new_key   = key_q;

    unique case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (fall_q) begin
          if (!dat_s) begin
            state_d = S_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall_q) begin
          shift_d = {dat_s, shift_q[BYTE_W-1:1]};
          if (bit_cnt_q == BCNT_W'(BYTE_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (fall_q) begin
          par_d   = dat_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall_q) begin
          stop_d  = dat_s;
          chk_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-edge watchdog inside a frame; prefix flags are deliberately kept
    if (state_q != S_IDLE && !fall_q) begin
      if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_d     = 1'b1;
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q + CNT_W'(1);
      end
    end

    // Stop bit and odd parity check, one cycle after the stop sample
    if (chk_q) begin
      if (stop_q && (^{shift_q, par_q})) begin
        good_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Decode a good byte into the held-key word
    if (good_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (!brk_q) begin
          new_key = {7'b0, ext_q, shift_q};
        end else if ({ext_q, shift_q} == key_q[8:0]) begin
          new_key = '0;
        end
        key_d    = new_key;
        strobe_d = (new_key != key_q);
        brk_d    = 1'b0;
        ext_d    = 1'b0;
      end
    end
  end

  // State register for filter, FSM, decode and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      chk_q     <= 1'b0;
      good_q    <= 1'b0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      key_q     <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      chk_q     <= chk_d;
      good_q    <= good_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      key_q     <= key_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign key_out    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_hack_kbd_ps2_rx.sv
// Directed bench for hack_kbd_ps2_rx: a frame table plus timeout, glitch and reset sequences.
module tb_hack_kbd_ps2_rx;

  localparam int unsigned FLEN = 8;
  localparam int unsigned TMO  = 1000;
  localparam int HALF = 20;
  localparam int GAP  = 40;
  localparam int NV   = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] key_out;
  logic        key_strobe;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int sc    = 0;
  int ec    = 0;
  int viol  = 0;
  logic [15:0] prev_key = 16'h0;

  typedef struct {
    logic [7:0]  code;
    logic        par_bad;
    logic        stop;
    logic [15:0] exp_key;
    int          exp_strb;
    int          exp_err;
  } vec_t;

  vec_t vecs [NV];

  hack_kbd_ps2_rx #(
    .FILTER_LEN    (FLEN),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_out   (key_out),
    .key_strobe(key_strobe),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Count pulses and flag any key_out change without a strobe (or strobe without change)
  always @(negedge clk) begin
    if (!rst) begin
      if (key_strobe) sc++;
      if (frame_err) ec++;
      if ((key_out != prev_key) != key_strobe) viol++;
    end
    prev_key = key_out;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop);
    ps2_bit(1'b0);
    for (int k = 0; k < 8; k++) ps2_bit(b[k]);
    ps2_bit((~^b) ^ par_bad);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic frame_check(input string name, input logic [7:0] b, input logic [15:0] ek,
                             input int es, input int ee);
    int s0, e0;
    s0 = sc;
    e0 = ec;
    send_frame(b, 1'b0, 1'b1);
    check({name, " key"}, 32'(key_out), 32'(ek));
    check({name, " strobes"}, 32'(sc - s0), 32'(es));
    check({name, " errs"}, 32'(ec - e0), 32'(ee));
  endtask

  initial begin
    int s0, e0, n;
    logic got;
    logic [7:0] b;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 16'h001C, 1, 0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 16'h001C, 0, 0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 16'h0000, 1, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b1, 16'h0000, 0, 0};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 16'h0175, 1, 0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b1, 16'h0175, 0, 0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b1, 16'h0175, 0, 0};
    vecs[7]  = '{8'h75, 1'b0, 1'b1, 16'h0000, 1, 0};
    vecs[8]  = '{8'h1C, 1'b0, 1'b1, 16'h001C, 1, 0};
    vecs[9]  = '{8'h1C, 1'b0, 1'b1, 16'h001C, 0, 0};
    vecs[10] = '{8'h1C, 1'b1, 1'b1, 16'h001C, 0, 1};
    vecs[11] = '{8'h32, 1'b0, 1'b1, 16'h0032, 1, 0};
    vecs[12] = '{8'hF0, 1'b0, 1'b1, 16'h0032, 0, 0};
    vecs[13] = '{8'h1C, 1'b0, 1'b1, 16'h0032, 0, 0};
    vecs[14] = '{8'h1C, 1'b0, 1'b1, 16'h001C, 1, 0};
    vecs[15] = '{8'h32, 1'b0, 1'b0, 16'h001C, 0, 1};
    vecs[16] = '{8'hF0, 1'b0, 1'b1, 16'h001C, 0, 0};
    vecs[17] = '{8'h1C, 1'b0, 1'b1, 16'h0000, 1, 0};

    // Reset state
    repeat (4) @(negedge clk);
    check("reset key", 32'(key_out), 32'h0);
    check("reset strobe", 32'(key_strobe), 32'h0);
    check("reset err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post-reset key", 32'(key_out), 32'h0);

    // Table of frames with carried make/break state
    for (int i = 0; i < NV; i++) begin
      s0 = sc;
      e0 = ec;
      send_frame(vecs[i].code, vecs[i].par_bad, vecs[i].stop);
      check($sformatf("row%0d key", i), 32'(key_out), 32'(vecs[i].exp_key));
      check($sformatf("row%0d strobes", i), 32'(sc - s0), 32'(vecs[i].exp_strb));
      check($sformatf("row%0d errs", i), 32'(ec - e0), 32'(vecs[i].exp_err));
    end

    // Timeout: start bit plus 4 data bits, then the clock stays high
    b = 8'h1C;
    ps2_bit(1'b0);
    for (int k = 0; k < 4; k++) ps2_bit(b[k]);
    ps2_data = 1'b1;
    e0 = ec;
    got = 1'b0;
    n = 0;
    while (!got && n < int'(TMO) + 200) begin
      @(negedge clk);
      n++;
      if (frame_err) got = 1'b1;
    end
    check("timeout fired", 32'(got), 32'h1);
    check("timeout window", 32'((n >= int'(TMO) - HALF) && (n <= int'(TMO) + 30)), 32'h1);
    repeat (GAP) @(negedge clk);
    check("timeout errs", 32'(ec - e0), 32'h1);
    check("timeout key", 32'(key_out), 32'h0);
    frame_check("after timeout", 8'h1C, 16'h001C, 1, 0);

    // Short low glitches on ps2_clk must not be taken as edges
    e0 = ec;
    for (int d = 0; d < 2; d++) begin
      ps2_data = d[0];
      for (int g = 0; g < 3; g++) begin
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (12) @(negedge clk);
      end
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    check("glitch errs", 32'(ec - e0), 32'h0);
    frame_check("after glitch", 8'h32, 16'h0032, 1, 0);

    // Reset in the middle of a frame
    b = 8'h5A;
    ps2_bit(1'b0);
    for (int k = 0; k < 3; k++) ps2_bit(b[k]);
    rst = 1'b1;
    #1;
    check("midrst key", 32'(key_out), 32'h0);
    check("midrst strobe", 32'(key_strobe), 32'h0);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
    frame_check("after midrst", 8'h1C, 16'h001C, 1, 0);

    check("strobe tracks change", 32'(viol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
